// File: rtl/cmd_pkg.sv
// Shared constants, error codes and one-hot FSM encoding for the command parser.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cmd_pkg;

  localparam logic [7:0] HEAD = 8'hEB;
  localparam logic [7:0] FLAG = 8'h90;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_HDR  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CHK  = 2'd3;

  typedef enum logic [7:0] {
    S_IDLE = 8'b0000_0001,
    S_H2   = 8'b0000_0010,
    S_CMD  = 8'b0000_0100,
    S_LEN  = 8'b0000_1000,
    S_DATA = 8'b0001_0000,
    S_CHK  = 8'b0010_0000,
    S_TAIL = 8'b0100_0000,
    S_DROP = 8'b1000_0000
  } state_t;

  // 8-bit wrap-around accumulate used for the frame checksum.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload store: MAXLEN x 8 registers, synchronous write, combinational read (0 beyond MAXLEN).
// Latency: write visible on the read port the cycle after i_we; read is zero-cycle.
// Backpressure: none; every write strobe is accepted.
module cmd_payload_buf #(
  parameter int MAXLEN = 16,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdat,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdat
);

  logic [7:0] r_mem    [MAXLEN];
  logic [7:0] w_rd_tbl [2**AW];

  for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mem
    // Per-entry register: cleared on reset, loaded when its address is written.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem[gi] <= 8'h00;
      end else if (i_we && (i_waddr == AW'(gi))) begin
        r_mem[gi] <= i_wdat;
      end
    end
  end

  // Addresses past the physical array read back as zero.
  for (genvar gr = 0; gr < 2**AW; gr++) begin : g_rd
    if (gr < MAXLEN) begin : g_live
      assign w_rd_tbl[gr] = r_mem[gr];
    end else begin : g_zero
      assign w_rd_tbl[gr] = 8'h00;
    end
  end

  assign o_rdat = w_rd_tbl[i_raddr];

endmodule

// File: rtl/cmd_parser.sv
// Parses EB 90 CMD LEN PAYLOAD CHK frames, checks the additive checksum, strobes cmd_valid or err.
// Latency: cmd_valid / err pulse exactly one cycle after cmdend.
// Backpressure: none; a byte is consumed every valid cycle. Optional CMD_PARSER_STAT_EN adds ok/err counters.
module cmd_parser
  import cmd_pkg::*;
#(
  parameter int MAXLEN = 16,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic [7:0]    din,
  input  logic          cmdend,
  output logic          cmd_valid,
  output logic [7:0]    cmd_code,
  output logic [7:0]    cmd_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err,
  output logic [1:0]    err_code
`ifdef CMD_PARSER_STAT_EN
  ,
  output logic [15:0]   ok_cnt,
  output logic [15:0]   err_cnt
`endif
);

  localparam logic [7:0] MAXLEN_B = 8'(MAXLEN);

  state_t        r_state;
  logic [7:0]    r_code_work;
  logic [7:0]    r_len_work;
  logic [7:0]    r_sum;
  logic [AW-1:0] r_cnt;
  logic [7:0]    r_chk;
  logic [1:0]    r_drop_code;
  logic          r_cmd_valid;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic [7:0]    r_cmd_code;
  logic [7:0]    r_cmd_len;

  state_t        w_st_byte;
  state_t        w_state_nxt;
  logic [7:0]    w_code_nxt;
  logic [7:0]    w_len_nxt;
  logic [7:0]    w_sum_nxt;
  logic [AW-1:0] w_cnt_nxt;
  logic [7:0]    w_chk_nxt;
  logic [1:0]    w_drop_nxt;
  logic          w_we;
  logic          w_ok_fire;
  logic          w_err_fire;
  logic [1:0]    w_err_code;
  logic          w_last;

  // Last payload byte when the running index reaches LEN-1.
  assign w_last = (8'(r_cnt) == (r_len_work - 8'd1));

  // Byte step first, then the end-of-frame decision on the post-byte state so a
  // CHK byte arriving together with cmdend is judged with its own value.
  always_comb begin
    w_st_byte  = r_state;
    w_code_nxt = r_code_work;
    w_len_nxt  = r_len_work;
    w_sum_nxt  = r_sum;
    w_cnt_nxt  = r_cnt;
    w_chk_nxt  = r_chk;
    w_drop_nxt = r_drop_code;
    w_we       = 1'b0;
    w_ok_fire  = 1'b0;
    w_err_fire = 1'b0;
    w_err_code = r_err_code;

    if (valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (din == HEAD) begin
            w_st_byte = S_H2;
          end else begin
            w_st_byte  = S_DROP;
            w_drop_nxt = ERR_HDR;
          end
        end
        S_H2: begin
          if (din == FLAG) begin
            w_st_byte = S_CMD;
          end else begin
            w_st_byte  = S_DROP;
            w_drop_nxt = ERR_HDR;
          end
        end
        S_CMD: begin
          w_code_nxt = din;
          w_sum_nxt  = din;
          w_st_byte  = S_LEN;
        end
        S_LEN: begin
          w_len_nxt = din;
          w_sum_nxt = sum8(r_sum, din);
          if (din > MAXLEN_B) begin
            w_st_byte  = S_DROP;
            w_drop_nxt = ERR_LEN;
          end else if (din == 8'h00) begin
            w_st_byte = S_CHK;
          end else begin
            w_st_byte = S_DATA;
            w_cnt_nxt = '0;
          end
        end
        S_DATA: begin
          w_we      = 1'b1;
          w_sum_nxt = sum8(r_sum, din);
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) begin
            w_st_byte = S_CHK;
          end
        end
        S_CHK: begin
          w_chk_nxt = din;
          w_st_byte = S_TAIL;
        end
        S_TAIL: begin
          w_st_byte  = S_DROP;
          w_drop_nxt = ERR_CHK;
        end
        S_DROP: begin
          w_st_byte = S_DROP;
        end
        default: begin
          w_st_byte = S_IDLE;
        end
      endcase
    end

    w_state_nxt = w_st_byte;

    if (cmdend) begin
      w_state_nxt = S_IDLE;
      case (w_st_byte)
        S_IDLE: begin
          w_ok_fire = 1'b0;
        end
        S_TAIL: begin
          if (w_sum_nxt == w_chk_nxt) begin
            w_ok_fire = 1'b1;
          end else begin
            w_err_fire = 1'b1;
            w_err_code = ERR_CHK;
          end
        end
        S_DROP: begin
          w_err_fire = 1'b1;
          w_err_code = w_drop_nxt;
        end
        default: begin
          // Frame ended before CHK arrived.
          w_err_fire = 1'b1;
          w_err_code = ERR_CHK;
        end
      endcase
    end
  end

  // FSM state and per-frame working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_code_work <= 8'h00;
      r_len_work  <= 8'h00;
      r_sum       <= 8'h00;
      r_cnt       <= '0;
      r_chk       <= 8'h00;
      r_drop_code <= ERR_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_code_work <= w_code_nxt;
      r_len_work  <= w_len_nxt;
      r_sum       <= w_sum_nxt;
      r_cnt       <= w_cnt_nxt;
      r_chk       <= w_chk_nxt;
      r_drop_code <= w_drop_nxt;
    end
  end

  // Result strobes; code/len and err_code only move when their strobe fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_cmd_code  <= 8'h00;
      r_cmd_len   <= 8'h00;
    end else begin
      r_cmd_valid <= w_ok_fire;
      r_err       <= w_err_fire;
      if (w_err_fire) begin
        r_err_code <= w_err_code;
      end
      if (w_ok_fire) begin
        r_cmd_code <= w_code_nxt;
        r_cmd_len  <= w_len_nxt;
      end
    end
  end

  cmd_payload_buf #(
    .MAXLEN (MAXLEN),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_cnt),
    .i_wdat  (din),
    .i_raddr (rd_addr),
    .o_rdat  (rd_data)
  );

  assign cmd_valid = r_cmd_valid;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign cmd_code  = r_cmd_code;
  assign cmd_len   = r_cmd_len;

`ifdef CMD_PARSER_STAT_EN
  logic [15:0] r_ok_cnt;
  logic [15:0] r_err_cnt;

  // Saturating accept/reject counters driven by the output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ok_cnt  <= 16'h0000;
      r_err_cnt <= 16'h0000;
    end else begin
      if (r_cmd_valid && (r_ok_cnt != 16'hFFFF)) begin
        r_ok_cnt <= r_ok_cnt + 16'd1;
      end
      if (r_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign ok_cnt  = r_ok_cnt;
  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_cmd_parser.sv
// Directed self-checking bench for cmd_parser: good, bad-checksum, oversize, bad header,
// long, short, max-length and same-cycle-cmdend frames, mid-frame reset, optional counters.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_cmd_parser;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [7:0] din;
  logic       cmdend;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       err;
  logic [1:0] err_code;
`ifdef CMD_PARSER_STAT_EN
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
`endif

  int n_cmp;
  int n_bad;
  logic [7:0] q[$];

  cmd_parser #(.MAXLEN(16), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .din       (din),
    .cmdend    (cmdend),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_len   (cmd_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .err       (err),
    .err_code  (err_code)
`ifdef CMD_PARSER_STAT_EN
    ,
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(negedge clk);
    valid  = v;
    din    = d;
    cmdend = e;
  endtask

  // Send every byte in q, one per cycle.
  task automatic send_q();
    foreach (q[i]) drive(1'b1, q[i], 1'b0);
  endtask

  // Pulse cmdend alone, then idle one cycle so the result strobe is visible.
  task automatic end_frame();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] s;
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    valid   = 1'b0;
    din     = 8'h00;
    cmdend  = 1'b0;
    rd_addr = 4'd0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_cmd_code",  32'(cmd_code),  32'h00);
    chk("rst_cmd_len",   32'(cmd_len),   32'h00);
    chk("rst_err_code",  32'(err_code),  32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'h00);
    rst_n = 1'b1;

    // Good frame: sum 01+02+AA+55 = 0x102 -> 02.
    q = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'hAA, 8'h55, 8'h02};
    send_q();
    end_frame();
    chk("a_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("a_err",       32'(err),       32'd0);
    chk("a_cmd_code",  32'(cmd_code),  32'h01);
    chk("a_cmd_len",   32'(cmd_len),   32'h02);
    rd_addr = 4'd0;
    #1 chk("a_rd0", 32'(rd_data), 32'hAA);
    rd_addr = 4'd1;
    #1 chk("a_rd1", 32'(rd_data), 32'h55);
    drive(1'b0, 8'h00, 1'b0);
    chk("a_pulse_end", 32'(cmd_valid), 32'd0);

    // Same frame, checksum 03 -> code 3, code/len held.
    q = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'hAA, 8'h55, 8'h03};
    send_q();
    end_frame();
    chk("b_err",       32'(err),       32'd1);
    chk("b_err_code",  32'(err_code),  32'd3);
    chk("b_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("b_cmd_code",  32'(cmd_code),  32'h01);
    chk("b_cmd_len",   32'(cmd_len),   32'h02);
    drive(1'b0, 8'h00, 1'b0);
    chk("b_err_pulse", 32'(err),       32'd0);
    chk("b_code_hold", 32'(err_code),  32'd3);

    // LEN=0x20 exceeds MAXLEN -> code 2.
    q = '{8'hEB, 8'h90, 8'h07, 8'h20, 8'h11, 8'h22, 8'h33};
    send_q();
    end_frame();
    chk("c_err",       32'(err),       32'd1);
    chk("c_err_code",  32'(err_code),  32'd2);
    chk("c_cmd_valid", 32'(cmd_valid), 32'd0);

    // Long frame: correct CHK (01+01+10=12) then an extra byte -> code 3.
    q = '{8'hEB, 8'h90, 8'h01, 8'h01, 8'h10, 8'h12, 8'hFF};
    send_q();
    end_frame();
    chk("d_err",       32'(err),       32'd1);
    chk("d_err_code",  32'(err_code),  32'd3);
    chk("d_cmd_valid", 32'(cmd_valid), 32'd0);

    // Bad second header byte -> code 1.
    q = '{8'hEB, 8'h91, 8'h00, 8'h00};
    send_q();
    end_frame();
    chk("e_err",      32'(err),      32'd1);
    chk("e_err_code", 32'(err_code), 32'd1);

    // LEN=0 with cmdend on the CHK byte itself.
    q = '{8'hEB, 8'h90, 8'h05, 8'h00};
    send_q();
    drive(1'b1, 8'h05, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    chk("f_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("f_err",       32'(err),       32'd0);
    chk("f_cmd_code",  32'(cmd_code),  32'h05);
    chk("f_cmd_len",   32'(cmd_len),   32'h00);

    // Maximum length frame: 16 bytes of i*0x11.
    q = '{8'hEB, 8'h90, 8'h3C, 8'h10};
    s = 8'h3C + 8'h10;
    for (int i = 0; i < 16; i++) begin
      q.push_back(8'(i * 17));
      s = s + 8'(i * 17);
    end
    q.push_back(s);
    send_q();
    end_frame();
    chk("g_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("g_cmd_code",  32'(cmd_code),  32'h3C);
    chk("g_cmd_len",   32'(cmd_len),   32'h10);
    rd_addr = 4'd15;
    #1 chk("g_rd15", 32'(rd_data), 32'hFF);
    rd_addr = 4'd7;
    #1 chk("g_rd7",  32'(rd_data), 32'h77);

    // Short frame: cmdend in DATA -> code 3, previous command held.
    q = '{8'hEB, 8'h90, 8'h01, 8'h02, 8'hAA};
    send_q();
    end_frame();
    chk("h_err",       32'(err),       32'd1);
    chk("h_err_code",  32'(err_code),  32'd3);
    chk("h_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("h_cmd_code",  32'(cmd_code),  32'h3C);

`ifdef CMD_PARSER_STAT_EN
    drive(1'b0, 8'h00, 1'b0);
    chk("s_ok_cnt",  32'(ok_cnt),  32'd3);
    chk("s_err_cnt", 32'(err_cnt), 32'd5);
`endif

    // Reset in the middle of a frame.
    q = '{8'hEB, 8'h90, 8'h01};
    send_q();
    drive(1'b1, 8'h02, 1'b0);
    rst_n   = 1'b0;
    valid   = 1'b0;
    rd_addr = 4'd0;
    #1;
    chk("r_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("r_err",       32'(err),       32'd0);
    chk("r_cmd_code",  32'(cmd_code),  32'h00);
    chk("r_cmd_len",   32'(cmd_len),   32'h00);
    chk("r_err_code",  32'(err_code),  32'd0);
    chk("r_rd_data",   32'(rd_data),   32'h00);
`ifdef CMD_PARSER_STAT_EN
    chk("r_ok_cnt",  32'(ok_cnt),  32'd0);
    chk("r_err_cnt", 32'(err_cnt), 32'd0);
`endif
    drive(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      chk("r_quiet_valid", 32'(cmd_valid), 32'd0);
      chk("r_quiet_err",   32'(err),       32'd0);
    end

    // cmdend while IDLE produces nothing.
    end_frame();
    chk("i_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("i_err",       32'(err),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Sits directly downstream of the command framer (EB90 header detector plus FIFO).
- Consumes the framed byte stream (valid/din) and the end-of-command strobe (cmdend).
- Parses frame layout EB 90 CMD LEN PAYLOAD[LEN] CHK and verifies the 8-bit additive checksum.
- Publishes a decoded command (code, length, payload read port) with a one-cycle strobe, or a coded error strobe.

Parameters:
- MAXLEN, 16, maximum payload bytes accepted; size of the payload register array.
- AW, 4, payload read-address width; must satisfy 2**AW >= MAXLEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  byte strobe from the framer; din is sampled when valid=1
- din  in  8  frame byte
- cmdend  in  1  one-cycle end-of-command pulse from the framer
- cmd_valid  out  1  one-cycle pulse: frame accepted
- cmd_code  out  8  CMD byte of the last accepted frame
- cmd_len  out  8  LEN byte of the last accepted frame
- rd_addr  in  AW  payload read index
- rd_data  out  8  payload[rd_addr], combinational; 8'h00 when rd_addr >= MAXLEN
- err  out  1  one-cycle pulse: frame rejected
- err_code  out  2  1=bad header, 2=LEN>MAXLEN, 3=checksum error or short/long frame; holds until the next err

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. All state is cleared on reset assertion.
- Reset values: cmd_valid=0, err=0, cmd_code=8'h00, cmd_len=8'h00, err_code=2'b00, payload array all 8'h00, state=IDLE.
- FSM states: IDLE, H2, CMD, LEN, DATA, CHK, TAIL, DROP.
- IDLE: valid with din==8'hEB -> H2. Any other byte -> DROP with err_code=1.
- H2: din==8'h90 -> CMD. Otherwise -> DROP with code 1.
- CMD: latch the code into a working register; sum=din -> LEN.
- LEN: LEN>MAXLEN -> DROP with code 2. LEN==0 -> CHK. Otherwise -> DATA, cnt=0. In all cases sum+=din.
- DATA: payload[cnt]=din, sum+=din, cnt++. When cnt==LEN-1 -> CHK.
- CHK: latch the received checksum -> TAIL.
- TAIL: any further valid byte -> DROP with code 3 (long frame).
- DROP: ignore bytes until cmdend.
- End of frame (cmdend=1):
  - In TAIL with sum[7:0]==CHK: next cycle cmd_valid=1, and cmd_code/cmd_len are updated from the working registers.
  - In TAIL with checksum mismatch: err=1, code 3.
  - In any state other than TAIL/DROP/IDLE: err=1, code 3 (short frame).
  - In DROP: err=1 with the stored code.
  - In IDLE: no output.
  - In every case, return to IDLE.
- Latency: cmd_valid/err occur exactly one cycle after cmdend.
- Simultaneous valid and cmdend: the byte is processed first, then the end-of-frame check is applied to the updated state.
- Checksum arithmetic: 8-bit wrap-around sum of CMD, LEN and all payload bytes; the header and CHK are excluded.
- Payload buffer: written live. Contents match cmd_len only from the cmd_valid pulse until the next frame's first DATA byte; the consumer must read within that window.
- cmd_code/cmd_len change only on cmd_valid.
- Reset mid-frame: the frame is discarded; no strobe is produced after reset release.

Optional Feature:
- Macro CMD_PARSER_STAT_EN.
- When defined: adds outputs ok_cnt[15:0] and err_cnt[15:0]. They increment on cmd_valid and on err respectively, saturate at 16'hFFFF, and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cmd_pkg: HEAD=8'hEB, FLAG=8'h90, ERR_HDR/ERR_LEN/ERR_CHK codes, FSM state encoding (one-hot, 8 bits).
- One natural sub-module: cmd_payload_buf, an MAXLEN x 8 register array with a synchronous write port and a combinational read port.

Test Plan:
- EB 90 01 02 AA 55 02, then cmdend -> cmd_valid one cycle after cmdend; cmd_code=01, cmd_len=02; rd_addr 0/1 -> AA/55; err stays 0.
- Same frame with CHK=03 -> err=1, err_code=3; cmd_code/cmd_len remain at their previous values.
- EB 90 07 20 (LEN=32 > 16) followed by bytes, then cmdend -> err_code=2; no cmd_valid.
- EB 91 ... then cmdend -> err_code=1. Next, EB 90 05 00 05 with cmdend asserted in the same cycle as the CHK byte -> cmd_valid, cmd_code=05, cmd_len=0.
- EB 90 01 02 AA, then cmdend (short frame) -> err_code=3. Assert rst_n low mid-frame -> all outputs at reset values, no strobe after release.
- With CMD_PARSER_STAT_EN defined: 3 good frames and 2 bad frames -> ok_cnt=3, err_cnt=2.
